// File: rtl/gate_truth_table_checker.sv
// Self-test sequencer for 2-input gates: walks {a,b} through 00..11, samples y
// after SETTLE cycles per vector and compares against the TRUTH table.
module gate_truth_table_checker #(
   parameter logic [3:0] TRUTH  = 4'b1110,
   parameter int         SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_vec
);

   localparam logic [3:0] SETTLE_L = 4'(SETTLE);

   typedef enum logic {IDLE, RUN} state_t;

   state_t     state, state_nxt;
   logic [1:0] idx, idx_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
   logic [2:0] err_count_nxt;
   logic [3:0] fail_vec_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= 2'd0;
         cnt       <= 4'd0;
         a         <= 1'b0;
         b         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= 3'd0;
         fail_vec  <= 4'd0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         cnt       <= cnt_nxt;
         a         <= a_nxt;
         b         <= b_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         pass      <= pass_nxt;
         err_count <= err_count_nxt;
         fail_vec  <= fail_vec_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      cnt_nxt       = cnt;
      a_nxt         = a;
      b_nxt         = b;
      busy_nxt      = busy;
      done_nxt      = done;
      pass_nxt      = pass;
      err_count_nxt = err_count;
      fail_vec_nxt  = fail_vec;
      case (state)
         IDLE: begin
            if (start) begin
               done_nxt      = 1'b0;
               pass_nxt      = 1'b0;
               err_count_nxt = 3'd0;
               fail_vec_nxt  = 4'd0;
               busy_nxt      = 1'b1;
               idx_nxt       = 2'd0;
               a_nxt         = 1'b0;
               b_nxt         = 1'b0;
               cnt_nxt       = SETTLE_L;
               state_nxt     = RUN;
            end
         end
         RUN: begin
            // cnt==1 means this edge would take the counter to 0: sample edge
            if (cnt == 4'd1) begin
               if (y != TRUTH[idx]) begin
                  fail_vec_nxt[idx] = 1'b1;
                  err_count_nxt     = err_count + 3'd1;
               end
               if (idx != 2'd3) begin
                  idx_nxt        = idx + 2'd1;
                  {a_nxt, b_nxt} = idx + 2'd1;
                  cnt_nxt        = SETTLE_L;
               end else begin
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  pass_nxt  = (err_count_nxt == 3'd0);
                  idx_nxt   = 2'd0;
                  a_nxt     = 1'b0;
                  b_nxt     = 1'b0;
                  cnt_nxt   = 4'd0;
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: two checkers (SETTLE=2 and SETTLE=1) against OR, stuck-0 and AND gates.
module tb_gate_truth_table_checker;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic sel = 1'b0;
   int   mode = 0;   // 0: OR gate, 1: y stuck at 0, 2: AND gate

   logic       a0, b0, busy0, done0, pass0, y0, start0;
   logic [2:0] err0;
   logic [3:0] fv0;
   logic       a1, b1, busy1, done1, pass1, y1, start1;
   logic [2:0] err1;
   logic [3:0] fv1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       pass;
      logic [2:0] err;
      logic [3:0] fv;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic gate(input int m, input logic aa, input logic bb);
      case (m)
         0:       return aa | bb;
         2:       return aa & bb;
         default: return 1'b0;
      endcase
   endfunction

   assign y0 = gate(mode, a0, b0);
   assign y1 = gate(mode, a1, b1);
   assign start0 = start & ~sel;
   assign start1 = start & sel;

   gate_truth_table_checker #(.TRUTH(4'b1110), .SETTLE(2)) dut (
      .clk(clk), .rst(rst), .start(start0), .y(y0),
      .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .fail_vec(fv0));

   gate_truth_table_checker #(.TRUTH(4'b1110), .SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .y(y1),
      .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_vec(fv1));

   wire [1:0] ab_o   = sel ? {a1, b1} : {a0, b0};
   wire       busy_o = sel ? busy1 : busy0;
   wire       done_o = sel ? done1 : done0;
   wire       pass_o = sel ? pass1 : pass0;
   wire [2:0] err_o  = sel ? err1 : err0;
   wire [3:0] fv_o   = sel ? fv1 : fv0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected result from the reference truth table OR = 4'b1110.
   task automatic push_expected(input int m);
      exp_t e;
      logic [3:0] ref_tt;
      ref_tt = 4'b1110;
      e.fv = 4'd0;
      e.err = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (gate(m, i[1], i[0]) !== ref_tt[i]) begin
            e.fv[i] = 1'b1;
            e.err   = e.err + 3'd1;
         end
      end
      e.pass = (e.err == 3'd0);
      sb.push_back(e);
   endtask

   // Pulses start at edge S, follows the run and checks the result.
   // restart_at >= 0 re-pulses start at edge S+restart_at+1 while busy.
   task automatic run_full(input string name, input logic s, input int m,
                           input int settle, input int restart_at);
      exp_t e;
      sel  = s;
      mode = m;
      push_expected(m);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({name, ".clear_done"}, done_o, 0);
      check({name, ".clear_err"}, err_o, 0);
      check({name, ".clear_fv"}, fv_o, 0);
      for (int j = 0; j < 4 * settle; j++) begin
         check({name, ".ab"}, ab_o, j / settle);
         check({name, ".busy"}, busy_o, 1);
         check({name, ".not_done"}, done_o, 0);
         if (j == restart_at) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      e = sb.pop_front();
      check({name, ".done"}, done_o, 1);
      check({name, ".busy_end"}, busy_o, 0);
      check({name, ".ab_end"}, ab_o, 0);
      check({name, ".pass"}, pass_o, e.pass);
      check({name, ".err_count"}, err_o, e.err);
      check({name, ".fail_vec"}, fv_o, e.fv);
      @(posedge clk); #1;
      check({name, ".done_sticky"}, done_o, 1);
      check({name, ".err_sticky"}, err_o, e.err);
   endtask

   task automatic check_reset_vals(input string name);
      check({name, ".a"}, a0, 0);
      check({name, ".b"}, b0, 0);
      check({name, ".busy"}, busy0, 0);
      check({name, ".done"}, done0, 0);
      check({name, ".pass"}, pass0, 0);
      check({name, ".err"}, err0, 0);
      check({name, ".fv"}, fv0, 0);
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_vals("reset");

      run_full("or_s2", 1'b0, 0, 2, -1);
      run_full("zero_s2", 1'b0, 1, 2, -1);
      run_full("or_after_fail", 1'b0, 0, 2, -1);
      run_full("and_s2", 1'b0, 2, 2, -1);
      run_full("or_s1", 1'b1, 0, 1, -1);
      run_full("zero_s1", 1'b1, 1, 1, -1);
      run_full("restart_ignored", 1'b0, 1, 2, 2);

      // Abort mid-run: rst at S+3
      sel = 1'b0;
      mode = 1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort.busy_before", busy0, 1);
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      check_reset_vals("abort");
      @(posedge clk); #1;
      check("abort.idle_busy", busy0, 0);
      run_full("after_abort", 1'b0, 0, 2, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Sequential stimulus/response companion for the team's 2-input gate blocks.
- Drives every input combination onto a gate-under-test and samples its output y after a programmable settle time.
- Compares each sample against a parameterised truth table and reports pass/fail, the mismatch count and which combinations failed.
- Used for on-chip self-test of the gate library.

Parameters:
- TRUTH, 4'b1110, expected y per input vector; bit i is the expected y for {a,b}=i (default is OR).
- SETTLE, 2, cycles each vector is held before y is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic is rising-edge triggered.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to run a full check.
- y  input  1  output of the gate-under-test.
- a  output  1  gate-under-test input a (MSB of vector index).
- b  output  1  gate-under-test input b (LSB of vector index).
- busy  output  1  high while a check is running.
- done  output  1  sticky completion flag.
- pass  output  1  valid when done=1; 1 means zero mismatches.
- err_count  output  3  number of mismatching vectors, 0..4.
- fail_vec  output  4  bit i set if vector {a,b}=i mismatched.

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high. All outputs are registered.
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0. Internal state is IDLE, idx=0, settle counter=0.
- rst has priority over everything, including start in the same cycle. Asserting rst mid-run aborts the run; the outputs above take their reset values at that edge.
- States: IDLE, RUN.
- IDLE, start=1 at edge S:
  - clear done, pass, err_count and fail_vec;
  - set busy=1, idx=0, {a,b}=2'b00;
  - load the settle counter with SETTLE and enter RUN.
- IDLE, start=0: hold all outputs. done, pass, err_count and fail_vec stay sticky.
- RUN, each cycle: decrement the settle counter. The edge where the counter would reach 0 is the sample edge.
- At a sample edge:
  - compare y with TRUTH[idx];
  - on a mismatch, set fail_vec[idx] and increment err_count.
- Sample edge with idx<3:
  - idx increments;
  - {a,b} takes the new idx at the same edge;
  - the counter reloads SETTLE.
- Sample edge with idx==3:
  - busy=0, done=1;
  - pass=1 only if no mismatch occurred across all 4 vectors, including the one sampled at this edge;
  - {a,b} returns to 00 and the state returns to IDLE.
- Timing:
  - each vector is driven for exactly SETTLE cycles;
  - samples occur at edges S+k*SETTLE for k=1..4;
  - done is visible after edge S+4*SETTLE, so latency is 4*SETTLE cycles.
- start while in RUN is ignored and has no effect on the current run.
- start in IDLE while done=1 restarts a run immediately; done drops at that edge.
- err_count never exceeds 4 and needs no wrap handling.
- y is sampled only at sample edges and ignored in all other cycles.

Test Plan:
- Correct OR gate connected, SETTLE=2, start pulsed at edge S:
  - {a,b} steps 00,01,10,11, two cycles each;
  - done=1 and busy=0 after S+8;
  - pass=1, err_count=0, fail_vec=0000.
- y tied to 0, default TRUTH: err_count=3, fail_vec=4'b1110, pass=0, done=1.
- AND gate connected with default TRUTH: err_count=2, fail_vec=4'b0110, pass=0.
- SETTLE=1, correct OR gate: a new vector every cycle; done after S+4; pass=1.
- rst asserted for one cycle at S+3 (SETTLE=2):
  - all outputs at reset values after that edge;
  - a later start runs a full, clean check with pass=1.
- start re-pulsed at S+3 while busy: ignored, and done still arrives at S+8. A start pulsed after done restarts the check: done clears and err_count/fail_vec reset to 0.
